// File: rtl/uart_mmio_pkg.sv
// Shared constants and types for the UART MMIO controller: select nibble,
// register offsets and the transmit FSM state encoding.
package uart_mmio_pkg;

  localparam logic [3:0] UART_SEL_DEF = 4'b1000;

  localparam logic [4:0] OFF_CTRL = 5'h00;
  localparam logic [4:0] OFF_RX   = 5'h04;
  localparam logic [4:0] OFF_TX   = 5'h08;
  localparam logic [4:0] OFF_CYC  = 5'h10;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate count.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MEM-stage MMIO front end for a UART: TX holding register with stall, RX
// buffer, cycle counter. Define UART_RX_FIFO_EN for a multi-entry RX FIFO.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter logic [3:0] UART_SEL      = UART_SEL_DEF,
  parameter int         RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  input  logic        wr_en,
  output logic [31:0] rdata,
  output logic        stall,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);

  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RX_FIFO_DEPTH must be a power of two >= 2");
  end

  logic        w_sel;
  logic [4:0]  w_off;
  logic        w_rd_rx;
  logic        w_wr_tx;
  logic        w_wr_cyc;
  logic        w_unused_bits;

  assign w_sel    = (addr[31:28] == UART_SEL);
  assign w_off    = addr[4:0];
  assign w_rd_rx  = rd_en && w_sel && (w_off == OFF_RX);
  assign w_wr_tx  = wr_en && w_sel && (w_off == OFF_TX);
  assign w_wr_cyc = wr_en && w_sel && (w_off == OFF_CYC);
  assign w_unused_bits = &{1'b0, addr[27:5], wdata[31:8]};

  // ---------------- transmit path ----------------
  tx_state_e r_state;
  tx_state_e w_state_nxt;
  logic [7:0] r_din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      IDLE: if (w_wr_tx) w_state_nxt = SEND;
      SEND: begin
        // Store is held by the CPU and retried; it lands once FSM is IDLE.
        stall = w_wr_tx;
        if (uart_din_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_din <= 8'h00;
    else if (r_state == IDLE && w_wr_tx) r_din <= wdata[7:0];
  end

  assign uart_din       = r_din;
  assign uart_din_valid = (r_state == SEND);

  // ---------------- receive path ----------------
  logic       w_rx_valid;
  logic [7:0] w_rx_byte;
  logic       w_rx_pop;

  assign w_rx_pop = w_rd_rx && w_rx_valid;

`ifdef UART_RX_FIFO_EN
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_push;

  assign w_push = uart_dout_valid && !w_fifo_full;

  uart_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (uart_dout),
    .i_pop   (w_rx_pop),
    .o_dout  (w_rx_byte),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign uart_dout_ready = !w_fifo_full;
  assign w_rx_valid      = !w_fifo_empty;
`else
  logic       r_rx_full;
  logic [7:0] r_rx_byte;

  // Ready is low while full, so a pop and a capture never share a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_full <= 1'b0;
      r_rx_byte <= 8'h00;
    end else if (uart_dout_valid && !r_rx_full) begin
      r_rx_full <= 1'b1;
      r_rx_byte <= uart_dout;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end
  end

  assign uart_dout_ready = !r_rx_full;
  assign w_rx_valid      = r_rx_full;
  assign w_rx_byte       = r_rx_byte;
`endif

  // ---------------- cycle counter ----------------
  logic [31:0] r_cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_cyc <= 32'h0;
    else if (w_wr_cyc) r_cyc <= 32'h0;
    else               r_cyc <= r_cyc + 32'h1;
  end

  // ---------------- load path ----------------
  logic [31:0] w_rdata;
  logic [31:0] r_rdata;

  always_comb begin
    w_rdata = 32'h0;
    if (w_sel) begin
      case (w_off)
        OFF_CTRL: w_rdata = {30'b0, w_rx_valid, (r_state == IDLE)};
        OFF_RX:   w_rdata = w_rx_valid ? {24'b0, w_rx_byte} : 32'h0;
        OFF_CYC:  w_rdata = r_cyc;
        default:  w_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_rdata <= 32'h0;
    else if (rd_en) r_rdata <= w_rdata;
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl; FIFO scenarios compile in with UART_RX_FIFO_EN.
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] rdata;
  logic        stall;
  logic [7:0]  uart_din;
  logic        uart_din_valid;
  logic        uart_din_ready;
  logic [7:0]  uart_dout;
  logic        uart_dout_valid;
  logic        uart_dout_ready;

  int n_pass  = 0;
  int n_total = 0;

  uart_mmio_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .addr            (addr),
    .wdata           (wdata),
    .rd_en           (rd_en),
    .wr_en           (wr_en),
    .rdata           (rdata),
    .stall           (stall),
    .uart_din        (uart_din),
    .uart_din_valid  (uart_din_valid),
    .uart_din_ready  (uart_din_ready),
    .uart_dout       (uart_dout),
    .uart_dout_valid (uart_dout_valid),
    .uart_dout_ready (uart_dout_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_total++;
    if (rdata !== 32'h0 || stall !== 1'b0 || uart_din !== 8'h00 ||
        uart_din_valid !== 1'b0 || uart_dout_ready !== 1'b1)
      $display("FAIL reset_outputs rdata=%h stall=%b din=%h dv=%b dr=%b exp 0/0/00/0/1",
               rdata, stall, uart_din, uart_din_valid, uart_dout_ready);
    else n_pass++;
    rst = 1'b0;
    tick();
    do_read(32'h8000_0000);
    n_total++;
    if (rdata !== 32'h1) $display("FAIL reset_ctrl got=%h exp=%h", rdata, 32'h1);
    else n_pass++;
  endtask

  task automatic test_tx();
    uart_din_ready = 1'b0;
    addr  = 32'h8000_0008;
    wdata = 32'hFFFF_FF41;
    wr_en = 1'b1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL tx_accept_stall got=%b exp=0", stall);
    else n_pass++;
    tick();
    wdata = 32'h0000_0042;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (stall !== 1'b1 || uart_din_valid !== 1'b1 || uart_din !== 8'h41)
        $display("FAIL tx_wait%0d stall=%b dv=%b din=%h exp 1/1/41", i, stall, uart_din_valid, uart_din);
      else n_pass++;
      tick();
    end
    uart_din_ready = 1'b1;
    n_total++;
    if (stall !== 1'b1 || uart_din_valid !== 1'b1 || uart_din !== 8'h41)
      $display("FAIL tx_handshake stall=%b dv=%b din=%h exp 1/1/41", stall, uart_din_valid, uart_din);
    else n_pass++;
    tick();
    n_total++;
    if (stall !== 1'b0 || uart_din_valid !== 1'b0 || uart_din !== 8'h41)
      $display("FAIL tx_idle_retry stall=%b dv=%b din=%h exp 0/0/41", stall, uart_din_valid, uart_din);
    else n_pass++;
    tick();
    wr_en = 1'b0;
    n_total++;
    if (uart_din_valid !== 1'b1 || uart_din !== 8'h42)
      $display("FAIL tx_second dv=%b din=%h exp 1/42", uart_din_valid, uart_din);
    else n_pass++;
    tick();
    n_total++;
    if (uart_din_valid !== 1'b0) $display("FAIL tx_second_done dv=%b exp=0", uart_din_valid);
    else n_pass++;
  endtask

  task automatic test_rx();
    uart_dout       = 8'h5A;
    uart_dout_valid = 1'b1;
    tick();
    uart_dout_valid = 1'b0;
    uart_dout       = 8'h00;
`ifndef UART_RX_FIFO_EN
    n_total++;
    if (uart_dout_ready !== 1'b0) $display("FAIL rx_full_ready got=%b exp=0", uart_dout_ready);
    else n_pass++;
`endif
    do_read(32'h8000_0000);
    n_total++;
    if (rdata !== 32'h3) $display("FAIL rx_ctrl_full got=%h exp=%h", rdata, 32'h3);
    else n_pass++;
    do_read(32'h8000_0004);
    n_total++;
    if (rdata !== 32'h5A || uart_dout_ready !== 1'b1)
      $display("FAIL rx_pop got=%h dr=%b exp=0000005a/1", rdata, uart_dout_ready);
    else n_pass++;
    do_read(32'h8000_0004);
    n_total++;
    if (rdata !== 32'h0) $display("FAIL rx_pop_empty got=%h exp=%h", rdata, 32'h0);
    else n_pass++;
    do_read(32'h8000_0000);
    n_total++;
    if (rdata !== 32'h1) $display("FAIL rx_ctrl_empty got=%h exp=%h", rdata, 32'h1);
    else n_pass++;
`ifndef UART_RX_FIFO_EN
    // Byte waiting during a pop is captured on the cycle after the pop.
    uart_dout       = 8'h77;
    uart_dout_valid = 1'b1;
    tick();
    uart_dout = 8'h78;
    do_read(32'h8000_0004);
    n_total++;
    if (rdata !== 32'h77 || uart_dout_ready !== 1'b1)
      $display("FAIL rx_pop_then_arrive got=%h dr=%b exp=00000077/1", rdata, uart_dout_ready);
    else n_pass++;
    tick();
    uart_dout_valid = 1'b0;
    do_read(32'h8000_0004);
    n_total++;
    if (rdata !== 32'h78) $display("FAIL rx_after_pop got=%h exp=%h", rdata, 32'h78);
    else n_pass++;
`endif
  endtask

`ifdef UART_RX_FIFO_EN
  task automatic test_fifo();
    logic [7:0] b;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      uart_dout       = b;
      uart_dout_valid = 1'b1;
      n_total++;
      if (uart_dout_ready !== (i <= 4))
        $display("FAIL fifo_ready_push%0d got=%b exp=%b", i, uart_dout_ready, (i <= 4));
      else n_pass++;
      tick();
    end
    uart_dout_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      do_read(32'h8000_0004);
      n_total++;
      if (rdata !== 32'(i)) $display("FAIL fifo_pop%0d got=%h exp=%h", i, rdata, 32'(i));
      else n_pass++;
    end
    do_read(32'h8000_0000);
    n_total++;
    if (rdata !== 32'h1) $display("FAIL fifo_drained got=%h exp=%h", rdata, 32'h1);
    else n_pass++;
    uart_dout = 8'hA0; uart_dout_valid = 1'b1;
    tick();
    uart_dout = 8'hA1;
    do_read(32'h8000_0004);
    uart_dout_valid = 1'b0;
    n_total++;
    if (rdata !== 32'hA0) $display("FAIL fifo_push_pop got=%h exp=%h", rdata, 32'hA0);
    else n_pass++;
    do_read(32'h8000_0004);
    n_total++;
    if (rdata !== 32'hA1) $display("FAIL fifo_count_kept got=%h exp=%h", rdata, 32'hA1);
    else n_pass++;
  endtask
`endif

  task automatic test_counter();
    addr  = 32'h8000_0010;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    repeat (10) tick();
    do_read(32'h8000_0010);
    n_total++;
    if (rdata !== 32'd10) $display("FAIL cyc_after_clear got=%0d exp=10", rdata);
    else n_pass++;
    do_read(32'h8000_0010);
    n_total++;
    if (rdata !== 32'd11) $display("FAIL cyc_increment got=%0d exp=11", rdata);
    else n_pass++;
    addr  = 32'h9000_0010;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    do_read(32'h8000_0010);
    n_total++;
    if (rdata !== 32'd13) $display("FAIL cyc_unselected_write got=%0d exp=13", rdata);
    else n_pass++;
  endtask

  task automatic test_decode();
    do_read(32'h9000_0000);
    n_total++;
    if (rdata !== 32'h0) $display("FAIL dec_unselected got=%h exp=0", rdata);
    else n_pass++;
    do_read(32'h8000_0000);
    do_read(32'h8000_000C);
    n_total++;
    if (rdata !== 32'h0) $display("FAIL dec_unmapped got=%h exp=0", rdata);
    else n_pass++;
    do_read(32'h8000_0000);
    repeat (2) tick();
    n_total++;
    if (rdata !== 32'h1) $display("FAIL dec_hold got=%h exp=1", rdata);
    else n_pass++;
    uart_din_ready = 1'b0;
    addr  = 32'h9000_0008;
    wdata = 32'h33;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_total++;
    if (uart_din_valid !== 1'b0 || uart_din !== 8'h42)
      $display("FAIL dec_tx_unselected dv=%b din=%h exp 0/42", uart_din_valid, uart_din);
    else n_pass++;
    // Load and store in the same cycle: TX data reads as 0, store still lands.
    addr  = 32'h8000_0008;
    wdata = 32'h66;
    wr_en = 1'b1;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_total++;
    if (rdata !== 32'h0 || uart_din_valid !== 1'b1 || uart_din !== 8'h66)
      $display("FAIL dec_rd_wr rdata=%h dv=%b din=%h exp 0/1/66", rdata, uart_din_valid, uart_din);
    else n_pass++;
    uart_din_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_send();
    uart_din_ready = 1'b0;
    addr  = 32'h8000_0008;
    wdata = 32'h55;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_total++;
    if (uart_din_valid !== 1'b1) $display("FAIL rst_send_pre dv=%b exp=1", uart_din_valid);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (uart_din_valid !== 1'b0 || uart_din !== 8'h00)
      $display("FAIL rst_async dv=%b din=%h exp 0/00", uart_din_valid, uart_din);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    do_read(32'h8000_0000);
    n_total++;
    if (rdata !== 32'h1) $display("FAIL rst_send_ctrl got=%h exp=%h", rdata, 32'h1);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    addr = 32'h0; wdata = 32'h0; rd_en = 1'b0; wr_en = 1'b0;
    uart_din_ready = 1'b0; uart_dout = 8'h00; uart_dout_valid = 1'b0;
    test_reset();
    test_tx();
    test_rx();
`ifdef UART_RX_FIFO_EN
    test_fifo();
`endif
    test_counter();
    test_decode();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
